// File: rtl/gas_alarm_controller.sv
// gas_alarm_controller
//
// Purpose:
//   Takes the 3-bit gas level from the detector stage and classifies it as
//   SAFE, WARN or DANGER. A state machine follows that class. A higher class
//   must hold for PERSIST cycles before the state escalates. A lower class
//   must hold for CLEAR cycles before the state steps down one level.
//   From the state it drives a fan speed command, a pulsed buzzer and a
//   sticky alarm latch. The operator must acknowledge the latch to clear it.
//
// Ports:
//   clk           - system clock, rising edge
//   arst          - synchronous, active-high reset
//   level[2:0]    - gas level from the detector stage, unsigned 0..7
//   ack           - operator acknowledge, level-sampled
//   state[1:0]    - FSM state: SAFE=00, WARN=01, DANGER=10
//   fan[1:0]      - fan speed: 0 off, 1 low, 2 purge, 3 full
//   buzzer        - audible alarm drive, square wave while latched
//   alarm_latched - sticky DANGER indicator
//   danger_events - 8-bit saturating count of DANGER entries
//                   (present only when GAS_ALARM_EVENT_CNT_EN is defined)
//
// Configuration:
//   Define GAS_ALARM_EVENT_CNT_EN to add the danger_events counter and port.
//   When the macro is undefined, the port and the counter are absent.

module gas_alarm_controller #(
    parameter int PERSIST   = 4,
    parameter int CLEAR     = 8,
    parameter int WARN_TH   = 3,
    parameter int DANGER_TH = 5,
    parameter int BUZZ_DIV  = 4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [2:0] level,
    input  logic       ack,
    output logic [1:0] state,
    output logic [1:0] fan,
    output logic       buzzer,
    output logic       alarm_latched
`ifdef GAS_ALARM_EVENT_CNT_EN
    ,
    output logic [7:0] danger_events
`endif
);

    localparam int         DIV_W      = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
    localparam logic [2:0] WARN_LVL   = 3'(WARN_TH);
    localparam logic [2:0] DANGER_LVL = 3'(DANGER_TH);
    localparam logic [3:0] PERSIST_C  = 4'(PERSIST);
    localparam logic [3:0] CLEAR_C    = 4'(CLEAR);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BUZZ_DIV - 1);

    typedef enum logic [1:0] {
        SAFE   = 2'b00,
        WARN   = 2'b01,
        DANGER = 2'b10
    } state_t;

    state_t           cur_state, nxt_state;
    state_t           cls, prev_cls;
    logic [3:0]       cnt, cnt_upd, nxt_cnt;
    logic [DIV_W-1:0] div, div_nxt;
    logic             latch_nxt, buzz_nxt;
    logic [1:0]       fan_nxt;
    logic             enter_danger, latch_clear;

    assign state = cur_state;

    // Classify the level. Escalation and de-escalation both work in terms of
    // this class, never in terms of the raw level.
    always_comb begin
        cls = SAFE;
        if (level >= DANGER_LVL) begin
            cls = DANGER;
        end else if (level >= WARN_LVL) begin
            cls = WARN;
        end
    end

    // Next-state logic, persistence counter, latch, buzzer and fan.
    // The counter restarts at 1 whenever the pending class changes, so a
    // one-cycle glitch into another class throws away the progress made so far.
    always_comb begin
        cnt_upd      = 4'd0;
        nxt_state    = cur_state;
        latch_nxt    = alarm_latched;
        buzz_nxt     = buzzer;
        div_nxt      = div;
        fan_nxt      = 2'd0;
        enter_danger = 1'b0;
        latch_clear  = 1'b0;

        if (cls == cur_state) begin
            cnt_upd = 4'd0;
        end else if (cls != prev_cls) begin
            cnt_upd = 4'd1;
        end else if (cnt == 4'd15) begin
            cnt_upd = 4'd15;
        end else begin
            cnt_upd = cnt + 4'd1;
        end
        nxt_cnt = cnt_upd;

        if ((cls > cur_state) && (cnt_upd >= PERSIST_C)) begin
            nxt_state = cls;
            nxt_cnt   = 4'd0;
        end else if ((cls < cur_state) && (cnt_upd >= CLEAR_C)) begin
            nxt_state = (cur_state == DANGER) ? WARN : SAFE;
            nxt_cnt   = 4'd0;
        end

        enter_danger = (nxt_state == DANGER) && (cur_state != DANGER);

        // A DANGER entry always wins over an acknowledge on the same edge.
        // An ack seen while in DANGER is simply dropped.
        latch_clear = ack && (cur_state != DANGER) && !enter_danger;

        if (enter_danger) begin
            latch_nxt = 1'b1;
        end else if (latch_clear) begin
            latch_nxt = 1'b0;
        end

        // The buzzer restarts its phase on every DANGER entry. It runs a
        // square wave of period 2*BUZZ_DIV while latched. It goes quiet on
        // the edge that clears the latch.
        if (enter_danger) begin
            buzz_nxt = 1'b1;
            div_nxt  = '0;
        end else if (alarm_latched && latch_clear) begin
            buzz_nxt = 1'b0;
            div_nxt  = '0;
        end else if (alarm_latched) begin
            if (div == DIV_LAST) begin
                buzz_nxt = ~buzzer;
                div_nxt  = '0;
            end else begin
                div_nxt  = div + DIV_W'(1);
            end
        end

        // Purge mode (fan=2) keeps ventilating after DANGER has passed
        // until the operator acknowledges the alarm.
        if (nxt_state == DANGER) begin
            fan_nxt = 2'd3;
        end else if (latch_nxt) begin
            fan_nxt = 2'd2;
        end else if (nxt_state == WARN) begin
            fan_nxt = 2'd1;
        end else begin
            fan_nxt = 2'd0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (arst) begin
            cur_state     <= SAFE;
            prev_cls      <= SAFE;
            cnt           <= 4'd0;
            div           <= '0;
            fan           <= 2'd0;
            buzzer        <= 1'b0;
            alarm_latched <= 1'b0;
        end else begin
            cur_state     <= nxt_state;
            prev_cls      <= cls;
            cnt           <= nxt_cnt;
            div           <= div_nxt;
            fan           <= fan_nxt;
            buzzer        <= buzz_nxt;
            alarm_latched <= latch_nxt;
        end
    end

`ifdef GAS_ALARM_EVENT_CNT_EN
    // Lifetime DANGER entry count. It saturates at 255, and only reset
    // clears it. An acknowledge leaves it unchanged.
    always_ff @(posedge clk) begin
        if (arst) begin
            danger_events <= 8'd0;
        end else if (enter_danger && (danger_events != 8'hFF)) begin
            danger_events <= danger_events + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gas_alarm_controller.sv
// tb_gas_alarm_controller
//
// Purpose:
//   Self-checking bench for gas_alarm_controller with default parameters.
//   A behavioural reference model computes the expected outputs whenever
//   stimulus is driven. It pushes them to a queue. After the clock edge the
//   queue entry is popped and compared with the DUT. Extra directed checks
//   pin key milestones to fixed constants.
//
// Ports: none (top-level bench).
// Configuration: honours GAS_ALARM_EVENT_CNT_EN for the danger_events port.

module tb_gas_alarm_controller;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic [2:0] level = 3'd0;
    logic       ack = 1'b0;
    logic [1:0] state;
    logic [1:0] fan;
    logic       buzzer;
    logic       alarm_latched;
    logic [7:0] events;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int st;
        int fn;
        int bz;
        int lt;
        int ev;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state.
    int m_state = 0, m_cnt = 0, m_prev = 0, m_latch = 0;
    int m_buzz = 0, m_div = 0, m_fan = 0, m_events = 0;

    gas_alarm_controller dut (
        .clk           (clk),
        .arst          (arst),
        .level         (level),
        .ack           (ack),
        .state         (state),
        .fan           (fan),
        .buzzer        (buzzer),
        .alarm_latched (alarm_latched)
`ifdef GAS_ALARM_EVENT_CNT_EN
        ,
        .danger_events (events)
`endif
    );

`ifndef GAS_ALARM_EVENT_CNT_EN
    assign events = 8'd0;
`endif

    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Steps the reference model by one clock edge for the given inputs.
    task automatic modelStep(input int lv, input int a, input int rst);
        int c, nc, ns, ent, clr;
        if (rst != 0) begin
            m_state = 0; m_cnt = 0; m_prev = 0; m_latch = 0;
            m_buzz = 0; m_div = 0; m_fan = 0; m_events = 0;
            return;
        end
        c = (lv >= 5) ? 2 : ((lv >= 3) ? 1 : 0);
        if (c == m_state) nc = 0;
        else if (c != m_prev) nc = 1;
        else nc = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
        ns = m_state;
        if (c > m_state && nc == 4) begin
            ns = c; nc = 0;
        end else if (c < m_state && nc == 8) begin
            ns = m_state - 1; nc = 0;
        end
        ent = (ns == 2 && m_state != 2) ? 1 : 0;
        clr = (ent == 0 && a != 0 && m_state != 2 && m_latch != 0) ? 1 : 0;
        if (ent != 0) begin
            m_buzz = 1; m_div = 0;
        end else if (clr != 0) begin
            m_buzz = 0; m_div = 0;
        end else if (m_latch != 0) begin
            if (m_div == 3) begin
                m_buzz = 1 - m_buzz; m_div = 0;
            end else begin
                m_div = m_div + 1;
            end
        end
        if (ent != 0) m_latch = 1;
        else if (clr != 0) m_latch = 0;
        if (ns == 2) m_fan = 3;
        else if (m_latch != 0) m_fan = 2;
        else m_fan = ns;
        if (ent != 0 && m_events < 255) m_events++;
        m_state = ns; m_cnt = nc; m_prev = c;
    endtask

    // Drives one cycle of inputs and queues the expected result. After the
    // edge it pops the queue and compares.
    task automatic applyStimulus(input int lv, input int a, input int rst);
        exp_t e, o;
        level = 3'(lv);
        ack   = (a != 0);
        arst  = (rst != 0);
        modelStep(lv, a, rst);
        e.st = m_state; e.fn = m_fan; e.bz = m_buzz; e.lt = m_latch; e.ev = m_events;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        checkOutput("state", int'(state), o.st);
        checkOutput("fan", int'(fan), o.fn);
        checkOutput("buzzer", int'(buzzer), o.bz);
        checkOutput("alarm_latched", int'(alarm_latched), o.lt);
`ifdef GAS_ALARM_EVENT_CNT_EN
        checkOutput("danger_events", int'(events), o.ev);
`endif
    endtask

    initial begin
        $display("[TB] start");
        @(negedge clk);

        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        checkOutput("rst_state", int'(state), 0);
        checkOutput("rst_fan", int'(fan), 0);

        // Plan 1: sustained DANGER level escalates on the 4th edge.
        for (int i = 0; i < 3; i++) applyStimulus(5, 0, 0);
        checkOutput("t1_still_safe", int'(state), 0);
        applyStimulus(5, 0, 0);
        checkOutput("t1_danger", int'(state), 2);
        checkOutput("t1_fan", int'(fan), 3);
        checkOutput("t1_latch", int'(alarm_latched), 1);
        checkOutput("t1_buzz_on", int'(buzzer), 1);
        for (int i = 0; i < 3; i++) applyStimulus(5, 0, 0);
        checkOutput("t1_buzz_hold", int'(buzzer), 1);
        applyStimulus(5, 0, 0);
        checkOutput("t1_buzz_toggle", int'(buzzer), 0);

        // Plan 3: step down through WARN to SAFE, then acknowledge.
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0);
        checkOutput("t3_warn", int'(state), 1);
        checkOutput("t3_purge", int'(fan), 2);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0);
        checkOutput("t3_safe", int'(state), 0);
        checkOutput("t3_purge_safe", int'(fan), 2);
        applyStimulus(0, 1, 0);
        checkOutput("t3_ack_latch", int'(alarm_latched), 0);
        checkOutput("t3_ack_buzz", int'(buzzer), 0);
        checkOutput("t3_ack_fan", int'(fan), 0);

        // Plan 2: a one-cycle dip restarts the persistence count.
        for (int i = 0; i < 3; i++) applyStimulus(3, 0, 0);
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(3, 0, 0);
        checkOutput("t2_no_warn", int'(state), 0);
        applyStimulus(3, 0, 0);
        checkOutput("t2_warn", int'(state), 1);
        checkOutput("t2_fan", int'(fan), 1);

        // Plan 4: ack held through DANGER is ignored until after step-down.
        for (int i = 0; i < 4; i++) applyStimulus(7, 1, 0);
        checkOutput("t4_danger", int'(state), 2);
        checkOutput("t4_latch_set", int'(alarm_latched), 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0);
        checkOutput("t4_warn", int'(state), 1);
        checkOutput("t4_latch_kept", int'(alarm_latched), 1);
        applyStimulus(0, 1, 0);
        checkOutput("t4_latch_drop", int'(alarm_latched), 0);

        // Plan 5: latched in WARN; re-entry with ack on the entry edge.
        for (int i = 0; i < 4; i++) applyStimulus(6, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(3, 0, 0);
        checkOutput("t5_warn_latched", int'(state), 1);
        for (int i = 0; i < 6; i++) applyStimulus(3, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(6, 0, 0);
        applyStimulus(6, 1, 0);
        checkOutput("t5_danger", int'(state), 2);
        checkOutput("t5_set_wins", int'(alarm_latched), 1);
        checkOutput("t5_buzz_restart", int'(buzzer), 1);

        // Plan 6: reset mid-DANGER, then two more entries.
        applyStimulus(6, 0, 1);
        checkOutput("t6_rst_state", int'(state), 0);
        checkOutput("t6_rst_latch", int'(alarm_latched), 0);
        checkOutput("t6_rst_buzz", int'(buzzer), 0);
`ifdef GAS_ALARM_EVENT_CNT_EN
        checkOutput("t6_rst_events", int'(events), 0);
`endif
        for (int i = 0; i < 4; i++) applyStimulus(6, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(6, 0, 0);
        checkOutput("t6_danger_again", int'(state), 2);
`ifdef GAS_ALARM_EVENT_CNT_EN
        checkOutput("t6_events_two", int'(events), 2);
`endif

        // Random levels with occasional acknowledges.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) ? 1 : 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
